// File: rtl/tengig_eth_loop_ctrl_if.sv
// Purpose: L2-RX / L3-TX stream handshake observation plus the per-stream frame-start holds.
// Latency: wires only; holds are decoded from the controller's registered state.
// Backpressure: holds ask the owner of the streams to gate tvalid/tready between frames.
interface tengig_eth_loop_ctrl_if;
    logic l2Tvalid;
    logic l2Tready;
    logic l2Tlast;
    logic l3Tvalid;
    logic l3Tready;
    logic l3Tlast;
    logic holdL2;
    logic holdL3;

    // Stream side: drives the observed handshakes, receives the holds.
    modport master (
        output l2Tvalid, l2Tready, l2Tlast,
        output l3Tvalid, l3Tready, l3Tlast,
        input  holdL2, holdL3
    );

    // Controller side.
    modport slave (
        input  l2Tvalid, l2Tready, l2Tlast,
        input  l3Tvalid, l3Tready, l3Tlast,
        output holdL2, holdL3
    );
endinterface

// File: rtl/tengig_eth_loop_ctrl.sv
// Purpose: turns the ETH0 L2/L3 loopback mux only between frames (drain, flip, settle); optional stats via TENGIG_LOOP_CTRL_STATS_EN.
// Latency: idle streams, req -> ack in 1 + 1 + gSettleCycles cycles; select flips on the edge that leaves DRAIN.
// Backpressure: holds block new frame starts during DRAIN/SETTLE; a drain stuck past gDrainTimeout aborts and latches a fault.
module tengig_eth_loop_ctrl #(
    parameter int gDrainTimeout = 1024,
    parameter int gSettleCycles = 4
) (
    input  logic                        piEthCoreClk,
    input  logic                        piResetN_a,
    input  logic                        piLoopbackReq,
    input  logic                        piErrClr,
    tengig_eth_loop_ctrl_if.slave       strm,
    output logic                        poMuxSel,
    output logic                        poLoopbackAck,
    output logic                        poBusy,
    output logic                        poDrainErr,
    output logic [31:0]                 poLoopFrameCnt,
    output logic [7:0]                  poAbortCnt
);

    typedef enum logic [2:0] {
        PASS      = 3'd0,
        DRAIN_LP  = 3'd1,
        SETTLE_LP = 3'd2,
        LOOP      = 3'd3,
        DRAIN_PS  = 3'd4,
        SETTLE_PS = 3'd5
    } state_t;

    state_t      state;
    logic        inFrameL2;
    logic        inFrameL3;
    logic        fault;
    logic [15:0] drainCnt;
    logic [3:0]  settleCnt;

    logic l2Beat;
    logic l3Beat;
    logic inDrain;
    logic inSettle;
    logic anyOpen;
    logic faultEff;
    logic withdrawn;
    logic drainTimeout;
    logic abortNow;

    assign l2Beat       = strm.l2Tvalid & strm.l2Tready;
    assign l3Beat       = strm.l3Tvalid & strm.l3Tready;
    assign inDrain      = (state == DRAIN_LP) || (state == DRAIN_PS);
    assign inSettle     = (state == SETTLE_LP) || (state == SETTLE_PS);
    assign anyOpen      = inFrameL2 | inFrameL3;
    // A clear pulse lets a blocked switch start on the same edge.
    assign faultEff     = fault & ~piErrClr;
    // Request no longer asks for the mode we are draining towards.
    assign withdrawn    = ((state == DRAIN_LP) & ~piLoopbackReq) | ((state == DRAIN_PS) & piLoopbackReq);
    assign drainTimeout = (drainCnt == 16'(gDrainTimeout - 1));
    assign abortNow     = inDrain & ~withdrawn & anyOpen & drainTimeout;

    // Holds only bite between frames while draining, and unconditionally while settling.
    assign strm.holdL2  = (inDrain & ~inFrameL2) | inSettle;
    assign strm.holdL3  = (inDrain & ~inFrameL3) | inSettle;
    assign poLoopbackAck = (state == LOOP);
    assign poBusy        = inDrain | inSettle;

    // Track open frames on each observed stream; single-beat frames never open one.
    always_ff @(posedge piEthCoreClk or negedge piResetN_a) begin
        if (!piResetN_a) begin
            inFrameL2 <= 1'b0;
            inFrameL3 <= 1'b0;
        end else begin
            if (l2Beat) inFrameL2 <= ~strm.l2Tlast;
            if (l3Beat) inFrameL3 <= ~strm.l3Tlast;
        end
    end

    // Switch sequencer: drain open frames, flip the select, settle, release.
    always_ff @(posedge piEthCoreClk or negedge piResetN_a) begin
        if (!piResetN_a) begin
            state     <= PASS;
            poMuxSel  <= 1'b0;
            drainCnt  <= '0;
            settleCnt <= '0;
        end else begin
            case (state)
                PASS: begin
                    drainCnt <= '0;
                    if (piLoopbackReq && !faultEff) state <= DRAIN_LP;
                end
                LOOP: begin
                    drainCnt <= '0;
                    if (!piLoopbackReq && !faultEff) state <= DRAIN_PS;
                end
                DRAIN_LP, DRAIN_PS: begin
                    if (withdrawn) begin
                        state <= (state == DRAIN_LP) ? PASS : LOOP;
                    end else if (!anyOpen) begin
                        state     <= (state == DRAIN_LP) ? SETTLE_LP : SETTLE_PS;
                        poMuxSel  <= ~poMuxSel;
                        settleCnt <= '0;
                    end else if (drainTimeout) begin
                        state <= (state == DRAIN_LP) ? PASS : LOOP;
                    end else begin
                        drainCnt <= drainCnt + 16'd1;
                    end
                end
                SETTLE_LP, SETTLE_PS: begin
                    if (settleCnt == 4'(gSettleCycles - 1)) begin
                        state <= (state == SETTLE_LP) ? LOOP : PASS;
                    end else begin
                        settleCnt <= settleCnt + 4'd1;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

    // Fault latch and sticky error: a new abort beats a same-cycle clear.
    always_ff @(posedge piEthCoreClk or negedge piResetN_a) begin
        if (!piResetN_a) begin
            fault      <= 1'b0;
            poDrainErr <= 1'b0;
        end else if (abortNow) begin
            fault      <= 1'b1;
            poDrainErr <= 1'b1;
        end else if (piErrClr) begin
            fault      <= 1'b0;
            poDrainErr <= 1'b0;
        end else if (piLoopbackReq == poMuxSel) begin
            fault      <= 1'b0;
        end
    end

`ifdef TENGIG_LOOP_CTRL_STATS_EN
    // Loopback frame count (wrapping) and abort count (saturating).
    always_ff @(posedge piEthCoreClk or negedge piResetN_a) begin
        if (!piResetN_a) begin
            poLoopFrameCnt <= '0;
            poAbortCnt     <= '0;
        end else begin
            if (state == LOOP && l2Beat && strm.l2Tlast) poLoopFrameCnt <= poLoopFrameCnt + 32'd1;
            if (abortNow && poAbortCnt != 8'hFF) poAbortCnt <= poAbortCnt + 8'd1;
        end
    end
`else
    assign poLoopFrameCnt = '0;
    assign poAbortCnt     = '0;
`endif

endmodule
